// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU op codes, FSM states, op legality.
package alu_arbiter_pkg;

  localparam int unsigned ALU_DW  = 8;
  localparam int unsigned ALU_OPW = 3;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // True for the op codes the ALU actually implements.
  function automatic logic op_legal(input logic [2:0] op);
    logic legal;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_NOR, ALU_SUB, ALU_SLT: legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: one-hot grant, favouring the requester not granted last.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant    = 2'b00;
    grant[0] = valid[0] & (~valid[1] | last);
    grant[1] = valid[1] & (~valid[0] | ~last);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two valid/ready requesters.
// Optional ALU_ARB_ERR_EN: illegal op codes are answered locally with rsp_err instead of issued.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DW  = ALU_DW,
  parameter int unsigned OPW = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*DW-1:0]  req_a,
  input  logic [2*DW-1:0]  req_b,
  input  logic [2*OPW-1:0] req_op,
  output logic [1:0]       rsp_valid,
  output logic [DW-1:0]    rsp_result,
  output logic             rsp_z,
  output logic             rsp_err,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [OPW-1:0]   alu_sel,
  input  logic [DW-1:0]    alu_result,
  input  logic             alu_z
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_q, grant_d;
  logic [DW-1:0]    alu_a_q, alu_a_d;
  logic [DW-1:0]    alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_sel_q, alu_sel_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_result_q, rsp_result_d;
  logic             rsp_z_q, rsp_z_d;

  logic [1:0]       pick;
  logic             pick_idx;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic [OPW-1:0]   in_op;

`ifdef ALU_ARB_ERR_EN
  logic             err_op_q, err_op_d;
  logic             rsp_err_q, rsp_err_d;
`endif

  rr_pick2 u_pick (
    .valid (req_valid),
    .last  (last_grant_q),
    .grant (pick)
  );

  // Operand mux for whichever requester the picker chose.
  always_comb begin
    pick_idx = pick[1];
    in_a     = pick_idx ? req_a[2*DW-1:DW]    : req_a[DW-1:0];
    in_b     = pick_idx ? req_b[2*DW-1:DW]    : req_b[DW-1:0];
    in_op    = pick_idx ? req_op[2*OPW-1:OPW] : req_op[OPW-1:0];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = 2'b00;
    rsp_result_d = rsp_result_q;
    rsp_z_d      = rsp_z_q;
    req_ready    = 2'b00;
`ifdef ALU_ARB_ERR_EN
    err_op_d     = err_op_q;
    rsp_err_d    = rsp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        req_ready = pick;
        if (|pick) begin
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          state_d      = ST_EXEC;
`ifdef ALU_ARB_ERR_EN
          // Illegal ops leave the ALU inputs untouched so the ALU never sees them.
          err_op_d = ~op_legal(3'(in_op));
          if (op_legal(3'(in_op))) begin
            alu_a_d   = in_a;
            alu_b_d   = in_b;
            alu_sel_d = in_op;
          end
`else
          alu_a_d   = in_a;
          alu_b_d   = in_b;
          alu_sel_d = in_op;
`endif
        end
      end
      ST_EXEC: begin
        rsp_valid_d = grant_q ? 2'b10 : 2'b01;
        state_d     = ST_IDLE;
`ifdef ALU_ARB_ERR_EN
        rsp_err_d    = err_op_q;
        rsp_result_d = err_op_q ? '0 : alu_result;
        rsp_z_d      = err_op_q ? 1'b1 : alu_z;
`else
        rsp_result_d = alu_result;
        rsp_z_d      = alu_z;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_result_q <= '0;
      rsp_z_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_z_q      <= rsp_z_d;
    end
  end

`ifdef ALU_ARB_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_op_q  <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      err_op_q  <= err_op_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_z      = rsp_z_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural 8-bit ALU attached.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [5:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_result;
  logic        rsp_z;
  logic        rsp_err;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_result;
  logic        alu_z;

  int n_cmp;
  int n_fail;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_z      (rsp_z),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_z      (alu_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU the arbiter feeds.
  always_comb begin
    case (alu_sel)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      3'b010:  alu_result = alu_a + alu_b;
      3'b011:  alu_result = ~(alu_a | alu_b);
      3'b110:  alu_result = alu_a - alu_b;
      3'b111:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 8'h01 : 8'h00;
      default: alu_result = 8'h00;
    endcase
    alu_z = (alu_result == 8'h00);
  end

  // Issue one op from requester idx and capture what is seen at each stage.
  task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op,
                        output logic [1:0] rdy, output logic [2:0] sel_exec,
                        output logic [7:0] a_exec, output logic [1:0] rv,
                        output logic [7:0] res, output logic z, output logic err);
    @(negedge clk);
    req_a = '0; req_b = '0; req_op = '0;
    if (idx == 0) begin
      req_a[7:0] = a; req_b[7:0] = b; req_op[2:0] = op; req_valid = 2'b01;
    end else begin
      req_a[15:8] = a; req_b[15:8] = b; req_op[5:3] = op; req_valid = 2'b10;
    end
    #1 rdy = req_ready;
    @(negedge clk);
    req_valid = 2'b00;
    sel_exec  = alu_sel;
    a_exec    = alu_a;
    @(negedge clk);
    rv  = rsp_valid;
    res = rsp_result;
    z   = rsp_z;
    err = rsp_err;
  endtask

  task automatic test_reset();
    logic [40:0] obs;
    rst_n = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0; req_op = '0;
    repeat (2) @(negedge clk);
    obs = {req_ready, rsp_valid, rsp_result, rsp_z, rsp_err, alu_a, alu_b, alu_sel};
    n_cmp++;
    if (obs !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_req0_add();
    logic [1:0] rdy, rv; logic [2:0] sel; logic [7:0] ae, res; logic z, err;
    run_op(0, 8'h05, 8'h03, 3'b010, rdy, sel, ae, rv, res, z, err);
    n_cmp++; if (rdy !== 2'b01) begin n_fail++; $display("FAIL add_ready: got %b expected 01", rdy); end
    n_cmp++; if (sel !== 3'b010) begin n_fail++; $display("FAIL add_alu_sel: got %b expected 010", sel); end
    n_cmp++; if (ae !== 8'h05) begin n_fail++; $display("FAIL add_alu_a: got %h expected 05", ae); end
    n_cmp++; if (rv !== 2'b01) begin n_fail++; $display("FAIL add_rsp_valid: got %b expected 01", rv); end
    n_cmp++; if (res !== 8'h08) begin n_fail++; $display("FAIL add_result: got %h expected 08", res); end
    n_cmp++; if (z !== 1'b0) begin n_fail++; $display("FAIL add_z: got %b expected 0", z); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL add_err: got %b expected 0", err); end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_result} !== {2'b00, 8'h08}) begin
      n_fail++;
      $display("FAIL add_hold: got valid=%b result=%h expected valid=00 result=08", rsp_valid, rsp_result);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [37:0] obs;
    @(negedge clk);
    req_a = {8'h00, 8'hFF}; req_b = {8'h00, 8'h0F}; req_op = {3'b000, 3'b010}; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1 obs = {rsp_valid, rsp_result, rsp_z, alu_a, alu_b, alu_sel, req_ready};
    n_cmp++;
    if (obs !== 38'd0) begin
      n_fail++;
      $display("FAIL midexec_reset_outputs: got %h expected 0", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_result} !== 10'd0) begin
        n_fail++;
        $display("FAIL midexec_no_rsp[%0d]: got valid=%b result=%h expected 00/00", i, rsp_valid, rsp_result);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    logic [7:0] exp_a;
    @(negedge clk);
    req_a = {8'h07, 8'hF0}; req_b = {8'h07, 8'h0F}; req_op = {3'b110, 3'b000}; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (k % 2 == 0) ? 8'hF0 : 8'h07;
      #1;
      n_cmp++;
      if (req_ready !== exp_g) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, req_ready, exp_g);
      end
      @(negedge clk);
      n_cmp++;
      if ({req_ready, rsp_valid, alu_a} !== {2'b00, 2'b00, exp_a}) begin
        n_fail++;
        $display("FAIL b2b_exec[%0d]: got ready=%b valid=%b alu_a=%h expected 00/00/%h", k, req_ready, rsp_valid, alu_a, exp_a);
      end
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, rsp_result, rsp_z} !== {exp_g, 8'h00, 1'b1}) begin
        n_fail++;
        $display("FAIL b2b_rsp[%0d]: got valid=%b result=%h z=%b expected %b/00/1", k, rsp_valid, rsp_result, rsp_z, exp_g);
      end
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_slt();
    logic [1:0] rdy, rv; logic [2:0] sel; logic [7:0] ae, res; logic z, err;
    run_op(1, 8'h02, 8'h09, 3'b111, rdy, sel, ae, rv, res, z, err);
    n_cmp++;
    if ({rdy, rv, res, z} !== {2'b10, 2'b10, 8'h01, 1'b0}) begin
      n_fail++; $display("FAIL slt_lt: got rdy=%b valid=%b result=%h z=%b expected 10/10/01/0", rdy, rv, res, z);
    end
    run_op(1, 8'h09, 8'h02, 3'b111, rdy, sel, ae, rv, res, z, err);
    n_cmp++;
    if ({rv, res, z} !== {2'b10, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL slt_ge: got valid=%b result=%h z=%b expected 10/00/1", rv, res, z);
    end
  endtask

  task automatic test_illegal_op();
    logic [1:0] rdy, rv; logic [2:0] sel; logic [7:0] ae, res; logic z, err;
    run_op(0, 8'h33, 8'h11, 3'b100, rdy, sel, ae, rv, res, z, err);
    n_cmp++; if (rv !== 2'b01) begin n_fail++; $display("FAIL illegal_rsp_valid: got %b expected 01", rv); end
`ifdef ALU_ARB_ERR_EN
    n_cmp++; if (sel !== 3'b111) begin n_fail++; $display("FAIL illegal_alu_sel: got %b expected 111", sel); end
    n_cmp++;
    if ({err, res, z} !== {1'b1, 8'h00, 1'b1}) begin
      n_fail++; $display("FAIL illegal_rsp: got err=%b result=%h z=%b expected 1/00/1", err, res, z);
    end
`else
    n_cmp++; if (sel !== 3'b100) begin n_fail++; $display("FAIL illegal_alu_sel: got %b expected 100", sel); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_err: got %b expected 0", err); end
`endif
  endtask

  task automatic test_exec_pulse();
    @(negedge clk);
    req_a = {8'h0A, 8'h55}; req_b = {8'h50, 8'h01}; req_op = {3'b001, 3'b010}; req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b01;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL pulse_ready_exec: got %b expected 00", req_ready);
    end
    @(negedge clk);
    req_valid = 2'b00;
    n_cmp++;
    if ({rsp_valid, rsp_result} !== {2'b10, 8'h5A}) begin
      n_fail++; $display("FAIL pulse_rsp: got valid=%b result=%h expected 10/5A", rsp_valid, rsp_result);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rsp_valid, req_ready, alu_a} !== {2'b00, 2'b00, 8'h0A}) begin
        n_fail++;
        $display("FAIL pulse_idle[%0d]: got valid=%b ready=%b alu_a=%h expected 00/00/0A", i, rsp_valid, req_ready, alu_a);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_req0_add();
    test_reset_mid_exec();
    test_back_to_back();
    test_slt();
    test_illegal_op();
    test_exec_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
